column_scheduler: RTL and testbench
===================================

// Module: column_scheduler
// PURPOSE
//  Sequences the three falling-byte columns of Flippy Bit: spawns LFSR bytes, advances their rows on a drop tick,
//  routes the player's fire+switch byte to the lowest active column, keeps score, detects game over.
//  Sits between button/SW inputs and Display (letter1..3, ypos1..3) / Binary_BCD (score).
// PARAMETERS
//  START_STEP  25_000_000  CLOCK_50 cycles per row step at game start
//  MIN_STEP    2_500_000   floor of step period
//  SPEEDUP     2_500_000   step period decrement every 4th hit
//  SPAWN_GAP   6           row steps between spawn attempts
//  ROWS        20          rows per column; bottom row = ROWS-1
//  LFSR_SEED   8'hA5       reset value of byte generator (nonzero)
// PORTS
//  CLOCK_50    in   1   50 MHz system clock
//  reset       in   1   asynchronous, active-high
//  fire        in   1   one-cycle pulse, debounced button
//  guess       in   8   player byte (SW[7:0])
//  col_active  out  3   bit i = column i holds a byte
//  col_letter  out  24  {letter3,letter2,letter1}; 0 when inactive
//  col_ypos    out  15  {ypos3,ypos2,ypos1}, 5 b each; 0 when inactive
//  score       out  8   hits this game, saturates at 255
//  game_over   out  1   high in OVER
//  hit         out  1   one-cycle pulse, correct guess
//  miss        out  1   one-cycle pulse, wrong guess
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; step period = START_STEP; counters 0; LFSR = LFSR_SEED.
//  - LFSR: 8-bit Galois, taps 0xB8, advances every clock in every state; never 0 so spawned letter is never 0.
//  - IDLE: fire -> RUN next edge; clears score, columns, step/spawn counters; period = START_STEP.
//  - RUN: step counter counts period-1..0; at 0 asserts internal step for one cycle and reloads.
//    * On step: each active column ypos+1. Spawn counter +1; at SPAWN_GAP it resets to 0 and, if any column is
//      inactive, the lowest-index inactive column is activated with ypos=0 and letter=current LFSR value.
//      First spawn occurs on the first step after entering RUN (spawn counter preset to SPAWN_GAP-1).
//    * Target = active column with largest ypos; tie -> lowest index.
//    * fire with no active column: ignored, no pulse.
//    * fire, guess==target letter: column cleared (active,letter,ypos -> 0); score+1 saturating; hit=1 next cycle.
//      Every 4th hit (score[1:0]==0 after increment) period -= SPEEDUP, floored at MIN_STEP; new period used
//      at next reload.
//    * fire, guess!=target letter: miss=1 next cycle; no other effect.
//    * Game over: step while an active column has ypos==ROWS-1 -> OVER (that column does not move).
//    * fire and step same cycle: fire is resolved first against pre-step ypos; a hit column neither moves
//      nor triggers OVER; the other columns step normally; spawn may reuse the column freed by the hit.
//  - OVER: game_over=1; columns and score frozen; fire -> IDLE (score stays visible until next start).
//  - All outputs registered; hit/miss/column update exactly 1 cycle after fire edge.
//  - reset during any state returns to reset values immediately, regardless of clock.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE=2'd0, RUN=2'd1, OVER=2'd2), NUM_COLS=3, YPOS_W=5.
//  - Sub-module: flippy_lfsr8 (CLOCK_50, reset, seed param, q[7:0]).
//  - Target select and hit compare combinational inside this block.
// TESTING (START_STEP=4, MIN_STEP=2, SPEEDUP=1, SPAWN_GAP=3, LFSR_SEED=8'hA5)
//  1. Reset, 10 idle cycles -> all outputs 0, game_over=0; fire -> RUN; first step (4 cycles) spawns col 0
//     with letter = LFSR value on that cycle, ypos 0.
//  2. Run 3 more steps -> col0 ypos=3, col1 spawned ypos 0; fire guess=col0 letter -> hit pulse,
//     col0 cleared, score=1.
//  3. fire with wrong guess -> miss pulse one cycle, columns and score unchanged; fire with none active -> no pulse.
//  4. Four hits -> step period drops 4->3 (measure step spacing); 8 hits -> 2; further hits stay at 2.
//  5. Let col0 reach ypos 19, next step -> game_over=1, all frozen; fire -> IDLE, score held.
//  6. fire (correct) on same cycle as step with col0 at ypos 19 -> hit, no game_over; reset asserted
//     mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/column_scheduler_pkg.sv
// Shared types and constants for the Flippy Bit column scheduler.
package column_scheduler_pkg;

   // Game phases; the encoding is visible on the debug state output.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam int NUM_COLS = 3;
   localparam int YPOS_W   = 5;
   localparam int LETTER_W = 8;
   localparam int CNT_W    = 32;

   // One step of the 8-bit Galois byte generator (right shift, feedback mask 0xB8).
   function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
      return {1'b0, q[7:1]} ^ (q[0] ? 8'hB8 : 8'h00);
   endfunction

endpackage

// File: rtl/column_scheduler_lfsr.sv
// Free-running byte generator supplying the letters of newly spawned columns.
// A nonzero seed keeps the sequence away from the all-zero lock-up state.
module flippy_lfsr8
   import column_scheduler_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   output logic [7:0] q
);

   // Advance every clock regardless of game phase.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         q <= SEED;
      end else begin
         q <= lfsr8_next(q);
      end
   end

endmodule

// File: rtl/column_scheduler.sv
// Flippy Bit column scheduler: spawns bytes into three falling columns, steps
// them down on a drop tick, resolves the player's fire against the lowest
// column, keeps the score and detects game over.
//
// Fire handshake: fire is a single-cycle strobe with guess valid in the same
// cycle; there is no backpressure. The result (hit or miss pulse, column
// clear, score) is visible on the registered outputs one cycle later.
module column_scheduler
   import column_scheduler_pkg::*;
#(
   parameter int         START_STEP = 25_000_000,
   parameter int         MIN_STEP   = 2_500_000,
   parameter int         SPEEDUP    = 2_500_000,
   parameter int         SPAWN_GAP  = 6,
   parameter int         ROWS       = 20,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        fire,
   input  logic [7:0]  guess,
   output logic [2:0]  col_active,
   output logic [23:0] col_letter,
   output logic [14:0] col_ypos,
   output logic [7:0]  score,
   output logic        game_over,
   output logic        hit,
   output logic        miss,
   output logic [1:0]  dbg_state
);

   localparam int IDX_W = $clog2(NUM_COLS);

   state_t                                  state;
   logic [NUM_COLS-1:0]                     active;
   logic [NUM_COLS-1:0][LETTER_W-1:0]       letter;
   logic [NUM_COLS-1:0][YPOS_W-1:0]         ypos;
   logic [CNT_W-1:0]                        step_cnt;
   logic [CNT_W-1:0]                        period;
   logic [CNT_W-1:0]                        period_dec;
   logic [7:0]                              spawn_cnt;
   logic [7:0]                              lfsr_q;
   logic [7:0]                              score_inc;

   logic                                    in_run;
   logic                                    step;
   logic                                    spawn_due;
   logic                                    tgt_valid;
   logic [IDX_W-1:0]                        tgt_idx;
   logic                                    fire_hit;
   logic                                    fire_miss;
   logic                                    bottom;
   logic                                    free_ok;
   logic [IDX_W-1:0]                        free_idx;
   logic [NUM_COLS-1:0]                     nxt_active;
   logic [NUM_COLS-1:0][LETTER_W-1:0]       nxt_letter;
   logic [NUM_COLS-1:0][YPOS_W-1:0]         nxt_ypos;

   flippy_lfsr8 #(
      .SEED     (LFSR_SEED)
   ) u_lfsr (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .q        (lfsr_q)
   );

   // Column state is held in registers; the outputs are straight views of them.
   assign col_active = active;
   assign col_letter = letter;
   assign col_ypos   = ypos;
   assign dbg_state  = state;

   assign in_run    = (state == RUN);
   assign step      = in_run && (step_cnt == '0);
   assign spawn_due = (spawn_cnt == 8'(SPAWN_GAP - 1));
   assign fire_hit  = in_run && fire && tgt_valid && (guess == letter[tgt_idx]);
   assign fire_miss = in_run && fire && tgt_valid && (guess != letter[tgt_idx]);
   assign score_inc = score + 8'd1;

   // Target is the lowest column on screen; equal heights go to the lowest index.
   always_comb begin
      tgt_valid = 1'b0;
      tgt_idx   = '0;
      for (int i = 0; i < NUM_COLS; i++) begin
         if (active[i] && (!tgt_valid || (ypos[i] > ypos[tgt_idx]))) begin
            tgt_valid = 1'b1;
            tgt_idx   = IDX_W'(i);
         end
      end
   end

   // Faster drop after a speedup, never below the floor period.
   always_comb begin
      if (period >= (CNT_W'(MIN_STEP) + CNT_W'(SPEEDUP))) begin
         period_dec = period - CNT_W'(SPEEDUP);
      end else begin
         period_dec = CNT_W'(MIN_STEP);
      end
   end

   // Next column contents: the hit is applied first, then the drop step and spawn
   // work on what is left, so a freed column may be refilled on the same edge.
   always_comb begin
      nxt_active = active;
      nxt_letter = letter;
      nxt_ypos   = ypos;
      bottom     = 1'b0;
      free_ok    = 1'b0;
      free_idx   = '0;
      if (fire_hit) begin
         nxt_active[tgt_idx] = 1'b0;
         nxt_letter[tgt_idx] = '0;
         nxt_ypos[tgt_idx]   = '0;
      end
      for (int i = 0; i < NUM_COLS; i++) begin
         if (nxt_active[i] && (ypos[i] == YPOS_W'(ROWS - 1))) begin
            bottom = 1'b1;
         end
      end
      for (int i = 0; i < NUM_COLS; i++) begin
         if (!nxt_active[i] && !free_ok) begin
            free_ok  = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
      // A column on the bottom row ends the game, so nothing moves on that step.
      if (step && !bottom) begin
         for (int i = 0; i < NUM_COLS; i++) begin
            if (nxt_active[i]) begin
               nxt_ypos[i] = ypos[i] + YPOS_W'(1);
            end
         end
         if (spawn_due && free_ok) begin
            nxt_active[free_idx] = 1'b1;
            nxt_letter[free_idx] = lfsr_q;
            nxt_ypos[free_idx]   = '0;
         end
      end
   end

   // Game FSM with drop timer, spawn pacing, score and pulse outputs.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         active    <= '0;
         letter    <= '0;
         ypos      <= '0;
         score     <= '0;
         game_over <= 1'b0;
         hit       <= 1'b0;
         miss      <= 1'b0;
         step_cnt  <= '0;
         spawn_cnt <= '0;
         period    <= CNT_W'(START_STEP);
      end else begin
         hit  <= 1'b0;
         miss <= 1'b0;
         case (state)
            IDLE: begin
               if (fire) begin
                  state     <= RUN;
                  active    <= '0;
                  letter    <= '0;
                  ypos      <= '0;
                  score     <= '0;
                  period    <= CNT_W'(START_STEP);
                  // Full period before the first step, which also spawns.
                  step_cnt  <= CNT_W'(START_STEP - 1);
                  spawn_cnt <= 8'(SPAWN_GAP - 1);
               end
            end
            RUN: begin
               active <= nxt_active;
               letter <= nxt_letter;
               ypos   <= nxt_ypos;
               hit    <= fire_hit;
               miss   <= fire_miss;
               if (fire_hit && (score != 8'hFF)) begin
                  score <= score_inc;
                  if (score_inc[1:0] == 2'b00) begin
                     period <= period_dec;
                  end
               end
               // Reload uses the period in force now; a speedup from this
               // same edge applies from the following reload.
               if (step) begin
                  step_cnt  <= period - CNT_W'(1);
                  spawn_cnt <= spawn_due ? 8'd0 : spawn_cnt + 8'd1;
                  if (bottom) begin
                     state     <= OVER;
                     game_over <= 1'b1;
                  end
               end else begin
                  step_cnt <= step_cnt - CNT_W'(1);
               end
            end
            OVER: begin
               if (fire) begin
                  state     <= IDLE;
                  game_over <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_column_scheduler.sv
// Bench for column_scheduler: a game-level reference model predicts every
// registered output each cycle; directed phases pin timing and speedup with
// literal values, then a randomized player runs several games.
`timescale 1ns/1ps
module tb_column_scheduler;

   localparam int         START_STEP = 4;
   localparam int         MIN_STEP   = 2;
   localparam int         SPEEDUP    = 1;
   localparam int         SPAWN_GAP  = 3;
   localparam int         ROWS       = 20;
   localparam logic [7:0] SEED       = 8'hA5;
   localparam int         W          = 55;

   logic        clk;
   logic        rst;
   logic        fire;
   logic [7:0]  guess;
   logic [2:0]  col_active;
   logic [23:0] col_letter;
   logic [14:0] col_ypos;
   logic [7:0]  score;
   logic        game_over;
   logic        hit;
   logic        miss;
   logic [1:0]  dbg_state;

   column_scheduler #(
      .START_STEP (START_STEP),
      .MIN_STEP   (MIN_STEP),
      .SPEEDUP    (SPEEDUP),
      .SPAWN_GAP  (SPAWN_GAP),
      .ROWS       (ROWS),
      .LFSR_SEED  (SEED)
   ) dut (
      .CLOCK_50   (clk),
      .reset      (rst),
      .fire       (fire),
      .guess      (guess),
      .col_active (col_active),
      .col_letter (col_letter),
      .col_ypos   (col_ypos),
      .score      (score),
      .game_over  (game_over),
      .hit        (hit),
      .miss       (miss),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         m_mode;            // 0 idle, 1 playing, 2 over
   int         m_period;
   int         m_wait;            // edges left until the next drop step
   int         m_since;           // steps since the last spawn attempt
   int         m_score;
   int         m_act [3];
   int         m_let [3];
   int         m_y   [3];
   logic [7:0] m_lfsr;
   bit         m_hit;
   bit         m_miss;
   logic [W-1:0] exp_q [$];

   function automatic logic [7:0] lfsr_ref(input logic [7:0] v);
      logic [7:0] s;
      s = v >> 1;
      if (v[0]) s = s ^ 8'hB8;
      return s;
   endfunction

   function automatic int model_target();
      int t;
      t = -1;
      for (int i = 0; i < 3; i++)
         if (m_act[i] != 0 && (t < 0 || m_y[i] > m_y[t])) t = i;
      return t;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_period = START_STEP; m_wait = 0; m_since = 0; m_score = 0;
      for (int i = 0; i < 3; i++) begin
         m_act[i] = 0; m_let[i] = 0; m_y[i] = 0;
      end
      m_lfsr = SEED; m_hit = 0; m_miss = 0;
   endtask

   task automatic model_clock(input bit f, input logic [7:0] g);
      int t; int p_now; int free; bit over; logic [7:0] cur;
      cur = m_lfsr;
      m_lfsr = lfsr_ref(m_lfsr);
      m_hit = 0; m_miss = 0;
      case (m_mode)
         0: if (f) begin
            m_mode = 1; m_score = 0; m_period = START_STEP;
            m_wait = START_STEP; m_since = SPAWN_GAP - 1;
            for (int i = 0; i < 3; i++) begin
               m_act[i] = 0; m_let[i] = 0; m_y[i] = 0;
            end
         end
         1: begin
            p_now = m_period;
            t = model_target();
            if (f && t >= 0) begin
               if (g == 8'(m_let[t])) begin
                  m_hit = 1; m_act[t] = 0; m_let[t] = 0; m_y[t] = 0;
                  if (m_score < 255) begin
                     m_score++;
                     if (m_score % 4 == 0)
                        m_period = (m_period - SPEEDUP < MIN_STEP) ? MIN_STEP : m_period - SPEEDUP;
                  end
               end else begin
                  m_miss = 1;
               end
            end
            m_wait--;
            if (m_wait == 0) begin
               m_wait = p_now;
               over = 0;
               for (int i = 0; i < 3; i++)
                  if (m_act[i] != 0 && m_y[i] == ROWS - 1) over = 1;
               if (over) begin
                  m_mode = 2;
               end else begin
                  for (int i = 0; i < 3; i++)
                     if (m_act[i] != 0) m_y[i]++;
                  m_since++;
                  if (m_since == SPAWN_GAP) begin
                     m_since = 0;
                     free = -1;
                     for (int i = 0; i < 3; i++)
                        if (m_act[i] == 0 && free < 0) free = i;
                     if (free >= 0) begin
                        m_act[free] = 1; m_let[free] = int'(cur); m_y[free] = 0;
                     end
                  end
               end
            end
         end
         default: if (f) m_mode = 0;
      endcase
   endtask

   function automatic logic [W-1:0] model_vec();
      logic [2:0] a; logic [23:0] l; logic [14:0] y;
      for (int i = 0; i < 3; i++) begin
         a[i]        = (m_act[i] != 0);
         l[i*8 +: 8] = 8'(m_let[i]);
         y[i*5 +: 5] = 5'(m_y[i]);
      end
      return {a, l, y, 8'(m_score), (m_mode == 2), m_hit, m_miss, 2'(m_mode)};
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_clock(fire, guess);
         exp_q.push_back(model_vec());
      end
   end

   // ---------------- scoreboard compare ----------------
   logic [W-1:0] e;
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            while (exp_q.size() > 1) void'(exp_q.pop_front());
            e = exp_q.pop_front();
            chk("columns", {col_active, col_letter, col_ypos}, e[54:13]);
            chk("score", score, e[12:5]);
            chk("flags", {game_over, hit, miss}, e[4:2]);
            chk("state", dbg_state, e[1:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse(input logic [7:0] g);
      fire = 1'b1; guess = g;
      tick();
      fire = 1'b0;
   endtask

   task automatic hit_target();
      int t; int n;
      n = 0;
      t = (m_mode == 1) ? model_target() : -1;
      while (t < 0 && n < 200) begin
         tick(); n++;
         t = (m_mode == 1) ? model_target() : -1;
      end
      if (t < 0) begin
         total++; bad++;
         $display("FAIL wait_target: got none after %0d cycles, want an active column", n);
      end else begin
         pulse(8'(m_let[t]));
      end
   endtask

   task automatic hits_until(input int s);
      int n;
      n = 0;
      while (m_score < s && n < 40) begin
         hit_target(); n++;
      end
   endtask

   task automatic measure_step(input string name, input int want);
      int c; int n; int seen; int ts [3]; logic [4:0] prev;
      c = -1; n = 0;
      while (c < 0 && n < 200) begin
         for (int i = 2; i >= 0; i--) if (m_act[i] != 0) c = i;
         if (c < 0) begin tick(); n++; end
      end
      if (c < 0) begin
         total++; bad++;
         $display("FAIL %s: got no active column, want one", name);
      end else begin
         prev = col_ypos[c*5 +: 5]; seen = 0; n = 0;
         while (seen < 3 && n < 200) begin
            tick(); n++;
            if (col_ypos[c*5 +: 5] != prev) begin
               ts[seen] = n; seen++; prev = col_ypos[c*5 +: 5];
            end
         end
         if (seen < 3) begin
            total++; bad++;
            $display("FAIL %s: got %0d row changes, want 3", name, seen);
         end else begin
            chk(name, ts[2] - ts[1], want);
         end
      end
   endtask

   // ---------------- stimulus ----------------
   int n; int r; int t; int saved; int mx;
   initial begin
      rst = 1'b1; fire = 1'b0; guess = 8'h00;
      chk("lfsr_ref_a5", lfsr_ref(8'hA5), 8'hEA);
      chk("lfsr_ref_ea", lfsr_ref(8'hEA), 8'h75);
      chk("lfsr_ref_75", lfsr_ref(8'h75), 8'h82);
      repeat (3) tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("idle_outputs", {col_active, col_letter, col_ypos, score, game_over, hit, miss, dbg_state}, 0);

      // start; first step four edges after the start edge spawns column 0
      pulse(8'h00);
      chk("run_state", dbg_state, 1);
      repeat (3) tick();
      chk("pre_spawn_active", col_active, 0);
      tick();
      chk("spawn_active", col_active, 3'b001);
      chk("spawn_ypos", col_ypos[4:0], 0);
      chk("spawn_letter_nonzero", (col_letter[7:0] != 8'h00), 1);
      repeat (12) tick();
      chk("col0_ypos3", col_ypos[4:0], 3);
      chk("col1_spawned", col_active, 3'b011);
      chk("col1_ypos0", col_ypos[9:5], 0);
      pulse(8'(m_let[0]));
      chk("hit_pulse", hit, 1);
      chk("hit_score", score, 1);
      chk("hit_cleared", col_active, 3'b010);
      tick();
      chk("hit_one_cycle", hit, 0);
      pulse(~8'(m_let[1]));
      chk("miss_pulse", miss, 1);
      chk("miss_score", score, 1);
      chk("miss_columns", col_active, 3'b010);
      pulse(8'(m_let[1]));
      chk("hit2_empty", col_active, 0);
      pulse(8'h5A);
      chk("empty_fire_no_pulse", {hit, miss}, 0);

      // speedup: period 4 -> 3 after 4 hits, 2 after 8, floored after 12
      hits_until(4);
      measure_step("period_after_4", 3);
      hits_until(8);
      measure_step("period_after_8", 2);
      hits_until(12);
      measure_step("period_after_12", 2);

      // let a column reach the bottom
      n = 0;
      while (m_mode != 2 && n < 3000) begin tick(); n++; end
      chk("over_flag", game_over, 1);
      mx = 0;
      for (int i = 0; i < 3; i++)
         if (col_active[i] && col_ypos[i*5 +: 5] > mx) mx = col_ypos[i*5 +: 5];
      chk("over_bottom_row", mx, 19);
      saved = m_score;
      repeat (5) tick();
      chk("over_score_frozen", score, saved);
      pulse(8'h00);
      chk("over_to_idle", {game_over, dbg_state}, 0);
      chk("idle_score_held", score, 12);

      // hit on the very step that would have ended the game
      pulse(8'h00);
      n = 0;
      while (!(m_mode == 1 && m_act[0] != 0 && m_y[0] == ROWS - 1 && m_wait == 1) && n < 2000) begin
         tick(); n++;
      end
      pulse(8'(m_let[0]));
      chk("edge_hit", hit, 1);
      chk("edge_no_over", {game_over, dbg_state}, 3'b001);
      chk("edge_col0_ypos", col_ypos[4:0], 0);
      chk("edge_score", score, 1);

      // asynchronous reset mid-game
      repeat (3) tick();
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("async_reset", {col_active, col_letter, col_ypos, score, game_over, hit, miss, dbg_state}, 0);
      tick(); tick();
      rst = 1'b0;

      // randomized play across several games
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(0, 99);
         if (fire) begin
            fire = 1'b0;
         end else if (m_mode != 1) begin
            fire = (r < 5);
            guess = 8'($urandom_range(0, 255));
         end else if (r < 12) begin
            t = model_target();
            fire = 1'b1;
            guess = (t >= 0) ? 8'(m_let[t]) : 8'($urandom_range(0, 255));
         end else if (r < 20) begin
            fire = 1'b1;
            guess = 8'($urandom_range(0, 255));
         end
         tick();
      end
      fire = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      bad++;
      $display("FAIL watchdog: got no end of test by %0t, want finish", $time);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
